// File: rtl/ex_muldiv_sequencer.sv
// EX-stage multiply/divide sequencer: shift-add multiply and restoring divide,
// one bit per cycle, owning HI/LO and stalling the front of the pipe while busy.
module ex_muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_data1,
    input  logic [WIDTH-1:0] i_data2,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic [WIDTH-1:0]     dividend_raw;
    logic                 is_div;
    logic                 neg_main;
    logic                 rem_neg;

    logic                 sign1, sign2;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   acc_next;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot, rem;
    logic [WIDTH-1:0]     hi_next, lo_next;

    // Signed ops run on magnitudes; signs are reapplied when HI/LO are written.
    always_comb begin
        sign1 = ~i_op[0] & i_data1[WIDTH-1];
        sign2 = ~i_op[0] & i_data2[WIDTH-1];
        mag1  = sign1 ? ('0 - i_data1) : i_data1;
        mag2  = sign2 ? ('0 - i_data2) : i_data2;
    end

    // Multiply: accumulator upper half gathers partial sums, lower half holds the
    // multiplier. Divide: upper half is the remainder, lower half shifts the
    // dividend out and the quotient in.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        diff      = rem_shift - {1'b0, opnd};
        if (!is_div)
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        else if (diff[WIDTH])
            acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        prod = neg_main ? ('0 - acc_next) : acc_next;
        quot = acc_next[WIDTH-1:0];
        rem  = acc_next[2*WIDTH-1:WIDTH];
        if (!is_div) begin
            hi_next = prod[2*WIDTH-1:WIDTH];
            lo_next = prod[WIDTH-1:0];
        end else if (opnd == '0) begin
            hi_next = dividend_raw;
            lo_next = '1;
        end else begin
            hi_next = rem_neg  ? ('0 - rem)  : rem;
            lo_next = neg_main ? ('0 - quot) : quot;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_IDLE;
            count        <= '0;
            acc          <= '0;
            opnd         <= '0;
            dividend_raw <= '0;
            is_div       <= 1'b0;
            neg_main     <= 1'b0;
            rem_neg      <= 1'b0;
            o_hi         <= '0;
            o_lo         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start && !i_flush) begin
                        state        <= S_RUN;
                        count        <= CNT_W'(WIDTH - 1);
                        is_div       <= i_op[1];
                        neg_main     <= sign1 ^ sign2;
                        rem_neg      <= sign1;
                        dividend_raw <= i_data1;
                        if (i_op[1]) begin
                            acc  <= {{WIDTH{1'b0}}, mag1};
                            opnd <= mag2;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, mag2};
                            opnd <= mag1;
                        end
                    end
                end
                S_RUN: begin
                    if (i_flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc   <= acc_next;
                        count <= count - CNT_W'(1);
                        if (count == '0) begin
                            state <= S_DONE;
                            o_hi  <= hi_next;
                            o_lo  <= lo_next;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stall is combinational so the issuing instruction is held in ID/EX.
    assign o_stall = (state == S_RUN) | ((state == S_IDLE) & i_start & ~i_flush);
    assign o_busy  = (state == S_RUN);
    assign o_done  = (state == S_DONE);

endmodule
